wb_banked_mem_bridge: RTL and testbench



---
 rtl/wb_banked_mem_bridge_if.sv | 30 +++
 rtl/wb_banked_mem_bridge.sv | 137 +++++++++++++
 tb/tb_wb_banked_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_banked_mem_bridge_if.sv
// ============================================================================
// Module   : wb_banked_mem_bridge_if
// Brief    : Wishbone classic bus bundle for the banked memory bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_banked_mem_bridge_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_ack_o, wb_err_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_ack_o, wb_err_o, wb_dat_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_banked_mem_bridge.sv
// ============================================================================
// Module   : wb_banked_mem_bridge
// Brief    : Wishbone classic slave bridging to NUM_BANKS single-port DFF RAMs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_banked_mem_bridge #(
    parameter int          ADDR_BITS    = 8,
    parameter int          NUM_BANKS    = 2,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK    = 32'hFFFF_F800
) (
    input  wire logic                   wb_clk_i,
    input  wire logic                   wb_rst_i,
    wb_banked_mem_bridge_if.slave       wb,
    output logic [3:0]                  WE,
    output logic [NUM_BANKS-1:0]        EN,
    output logic [31:0]                 Di,
    input  wire logic [32*NUM_BANKS-1:0] Do,
    output logic [ADDR_BITS-1:0]        A
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [1:0] c_CNT_LOAD = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RWAIT  = 3'd2,
        S_RACK   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BANK_BITS-1:0]   r_bank;
    logic [BANK_BITS-1:0]   w_bank;
    logic                   r_we;
    logic [1:0]             r_cnt;
    logic [31:0]            r_dat_o;
    logic [ADDR_BITS-1:0]   w_word;
    logic                   w_valid;
    logic                   w_hit;
    logic                   w_start;
    logic                   w_capture;

    assign w_valid = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_hit   = (wb.wb_adr_i & ADDR_MASK) == BASE_ADDR;
    assign w_word  = wb.wb_adr_i[ADDR_BITS+1:2];

    generate
        if (NUM_BANKS > 1) begin : g_bank_multi
            assign w_bank = wb.wb_adr_i[ADDR_BITS+BANK_BITS+1:ADDR_BITS+2];
        end else begin : g_bank_single
            assign w_bank = '0;
        end
    endgenerate

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    if (w_hit) begin
                        w_next  = S_ACCESS;
                        w_start = 1'b1;
                    end else begin
                        w_next = S_ERR;
                    end
                end
            end
            // Writes finish here even if the master drops cyc
            S_ACCESS: w_next = r_we ? S_IDLE : S_RWAIT;
            S_RWAIT: begin
                if (!wb.wb_cyc_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 2'd0) begin
                    w_capture = 1'b1;
                    w_next    = S_RACK;
                end
            end
            S_RACK:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_bank  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= 2'd0;
            r_dat_o <= 32'd0;
            EN      <= '0;
            WE      <= 4'd0;
            A       <= '0;
            Di      <= 32'd0;
        end else begin
            r_state <= w_next;
            // Memory strobes are live only for the single ACCESS cycle
            EN      <= '0;
            WE      <= 4'd0;
            A       <= '0;
            Di      <= 32'd0;
            if (w_start) begin
                r_bank <= w_bank;
                r_we   <= wb.wb_we_i;
                EN     <= NUM_BANKS'(1) << w_bank;
                A      <= w_word;
                Di     <= wb.wb_dat_i;
                WE     <= wb.wb_we_i ? wb.wb_sel_i : 4'd0;
            end
            if (r_state == S_ACCESS) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == S_RWAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_capture) begin
                r_dat_o <= Do[32*int'(r_bank) +: 32];
            end
        end
    end

    // Read ack is qualified by cyc so an abort during RACK produces no ack
    assign wb.wb_ack_o = ((r_state == S_ACCESS) & r_we) |
                         ((r_state == S_RACK) & wb.wb_cyc_i);
    assign wb.wb_err_o = (r_state == S_ERR);
    assign wb.wb_dat_o = r_dat_o;

endmodule

`default_nettype wire

// File: tb/tb_wb_banked_mem_bridge.sv
// ============================================================================
// Module   : tb_wb_banked_mem_bridge
// Brief    : Self-checking bench; latency-1 and latency-3 bridges with RAM models.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_banked_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    int          tgt = 0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    wb_banked_mem_bridge_if bus0();
    wb_banked_mem_bridge_if bus1();

    assign bus0.wb_adr_i = adr;
    assign bus0.wb_dat_i = dat;
    assign bus0.wb_sel_i = sel;
    assign bus0.wb_we_i  = we;
    assign bus0.wb_cyc_i = cyc && (tgt == 0);
    assign bus0.wb_stb_i = stb && (tgt == 0);
    assign bus1.wb_adr_i = adr;
    assign bus1.wb_dat_i = dat;
    assign bus1.wb_sel_i = sel;
    assign bus1.wb_we_i  = we;
    assign bus1.wb_cyc_i = cyc && (tgt == 1);
    assign bus1.wb_stb_i = stb && (tgt == 1);

    logic [1:0]  en_a [2];
    logic [3:0]  we_a [2];
    logic [31:0] di_a [2];
    logic [7:0]  a_a  [2];
    logic [63:0] do_a [2];

    wb_banked_mem_bridge #(.READ_LATENCY(1)) dut0 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb (bus0.slave),
        .WE (we_a[0]), .EN (en_a[0]), .Di (di_a[0]), .Do (do_a[0]), .A (a_a[0])
    );

    wb_banked_mem_bridge #(.READ_LATENCY(3)) dut1 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb (bus1.slave),
        .WE (we_a[1]), .EN (en_a[1]), .Di (di_a[1]), .Do (do_a[1]), .A (a_a[1])
    );

    // Behavioural single-port RAM macros with LAT-cycle read pipeline
    for (genvar d = 0; d < 2; d++) begin : g_ram
        localparam int LAT = (d == 0) ? 1 : 3;
        logic [31:0] mem [2][256];
        logic [31:0] pd  [LAT];
        logic        pv  [LAT];
        logic        pbk [LAT];

        initial begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < 256; w++)
                    mem[b][w] <= 32'd0;
            for (int i = 0; i < LAT; i++) begin
                pd[i] <= 32'd0; pv[i] <= 1'b0; pbk[i] <= 1'b0;
            end
        end

        always @(posedge clk) begin
            for (int b = 0; b < 2; b++)
                if (en_a[d][b])
                    for (int i = 0; i < 4; i++)
                        if (we_a[d][i]) mem[b][a_a[d]][8*i +: 8] <= di_a[d][8*i +: 8];
            pd[0]  <= en_a[d][1] ? mem[1][a_a[d]] : mem[0][a_a[d]];
            pv[0]  <= |en_a[d];
            pbk[0] <= en_a[d][1];
            for (int i = 1; i < LAT; i++) begin
                pd[i] <= pd[i-1]; pv[i] <= pv[i-1]; pbk[i] <= pbk[i-1];
            end
        end

        assign do_a[d] = {(pv[LAT-1] &&  pbk[LAT-1]) ? pd[LAT-1] : 32'hBAD0_0001,
                          (pv[LAT-1] && !pbk[LAT-1]) ? pd[LAT-1] : 32'hBAD0_0000};
    end

    logic        ack_m, err_m;
    logic [31:0] dat_m, di_m;
    logic [1:0]  en_m;
    logic [3:0]  we_m;
    logic [7:0]  a_m;
    assign ack_m = (tgt == 0) ? bus0.wb_ack_o : bus1.wb_ack_o;
    assign err_m = (tgt == 0) ? bus0.wb_err_o : bus1.wb_err_o;
    assign dat_m = (tgt == 0) ? bus0.wb_dat_o : bus1.wb_dat_o;
    assign en_m  = (tgt == 0) ? en_a[0] : en_a[1];
    assign we_m  = (tgt == 0) ? we_a[0] : we_a[1];
    assign a_m   = (tgt == 0) ? a_a[0]  : a_a[1];
    assign di_m  = (tgt == 0) ? di_a[0] : di_a[1];

    logic [31:0] exp_mem [2][2][256];
    logic [31:0] last_rd [2];
    logic [31:0] sb_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input logic w, input logic [31:0] ad, input logic [31:0] d,
                            input logic [3:0] s, output int done_cyc, output logic [1:0] resp,
                            output logic [1:0] en_s, output logic [3:0] we_s,
                            output logic [7:0] a_s, output logic [31:0] di_s);
        int   n;
        logic hit;
        hit = (ad & 32'hFFFF_F800) == 32'h3000_0000;
        @(negedge clk);
        adr = ad; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        if (hit && !w) sb_q.push_back(exp_mem[tgt][ad[10]][ad[9:2]]);
        if (hit && w)
            for (int i = 0; i < 4; i++)
                if (s[i]) exp_mem[tgt][ad[10]][ad[9:2]][8*i +: 8] = d[8*i +: 8];
        done_cyc = -1; resp = 2'b00; en_s = '0; we_s = '0; a_s = '0; di_s = '0; n = 0;
        while (done_cyc < 0 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
            if (en_m != 2'b00) begin
                en_s = en_m; we_s = we_m; a_s = a_m; di_s = di_m;
            end
            if (ack_m || err_m) begin
                done_cyc = n;
                resp = {ack_m, err_m};
                if (ack_m && !w && hit) begin
                    if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
                    else begin
                        last_rd[tgt] = sb_q.pop_front();
                        check("rdata", {32'd0, dat_m}, {32'd0, last_rd[tgt]});
                    end
                end
                if (err_m) check("err_dat_hold", {32'd0, dat_m}, {32'd0, last_rd[tgt]});
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (done_cyc < 0) check("timeout", 64'd1, 64'd0);
        @(posedge clk); @(negedge clk);
        check("single_pulse", {62'd0, ack_m, err_m}, 64'd0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] ad;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e_err;
        logic [1:0]  e_en;
        logic [7:0]  e_a;
        logic [3:0]  e_we;
    } vec_t;

    vec_t vt [9];

    initial begin
        int          lat;
        logic [1:0]  resp, en_s;
        logic [3:0]  we_s;
        logic [7:0]  a_s;
        logic [31:0] di_s;
        logic        ack_seen;

        for (int t = 0; t < 2; t++) begin
            last_rd[t] = 32'd0;
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < 256; w++) exp_mem[t][b][w] = 32'd0;
        end

        vt[0] = '{1'b1, 32'h3000_0404, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'b10, 8'h01, 4'hF};
        vt[1] = '{1'b0, 32'h3000_0404, 32'h0000_0000, 4'hF, 1'b0, 2'b10, 8'h01, 4'h0};
        vt[2] = '{1'b1, 32'h3000_0010, 32'h1122_3344, 4'h4, 1'b0, 2'b01, 8'h04, 4'h4};
        vt[3] = '{1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 2'b01, 8'h04, 4'h0};
        vt[4] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 1'b0, 2'b01, 8'h04, 4'h0};
        vt[5] = '{1'b0, 32'h3000_0800, 32'h0000_0000, 4'hF, 1'b1, 2'b00, 8'h00, 4'h0};
        vt[6] = '{1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, 1'b1, 2'b00, 8'h00, 4'h0};
        vt[7] = '{1'b1, 32'h3000_07FC, 32'hCAFE_F00D, 4'hF, 1'b0, 2'b10, 8'hFF, 4'hF};
        vt[8] = '{1'b0, 32'h3000_07FC, 32'h0000_0000, 4'hF, 1'b0, 2'b10, 8'hFF, 4'h0};

        #1 rst = 1'b1;
        #2;
        check("reset_dut0", {en_a[0], we_a[0], a_a[0], bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o},
              64'd0);
        check("reset_dut1", {en_a[1], we_a[1], a_a[1], bus1.wb_ack_o, bus1.wb_err_o, bus1.wb_dat_o},
              64'd0);
        check("reset_di", {di_a[1], di_a[0]}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        tgt = 0;
        for (int i = 0; i < 9; i++) begin
            run_xfer(vt[i].w, vt[i].ad, vt[i].d, vt[i].s, lat, resp, en_s, we_s, a_s, di_s);
            check($sformatf("v%0d_latency", i), 64'(lat),
                  (vt[i].e_err || vt[i].w) ? 64'd1 : 64'd3);
            check($sformatf("v%0d_resp", i), {62'd0, resp}, vt[i].e_err ? 64'd1 : 64'd2);
            check($sformatf("v%0d_strobes", i), {50'd0, en_s, we_s, a_s},
                  {50'd0, vt[i].e_en, vt[i].e_we, vt[i].e_a});
            if (vt[i].w && !vt[i].e_err)
                check($sformatf("v%0d_di", i), {32'd0, di_s}, {32'd0, vt[i].d});
        end

        // Latency-3 bridge: write, then a read aborted in its second RWAIT cycle
        tgt = 1;
        run_xfer(1'b1, 32'h3000_0008, 32'h5A5A_1234, 4'hF, lat, resp, en_s, we_s, a_s, di_s);
        check("l3_wr_latency", 64'(lat), 64'd1);
        @(negedge clk);
        adr = 32'h3000_0008; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        ack_seen = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); @(negedge clk);
            ack_seen = ack_seen | ack_m | err_m;
            if (n == 3) begin cyc = 1'b0; stb = 1'b0; end
        end
        check("abort_no_ack", {63'd0, ack_seen}, 64'd0);
        check("abort_dat_hold", {32'd0, dat_m}, {32'd0, last_rd[1]});

        run_xfer(1'b0, 32'h3000_0008, 32'd0, 4'hF, lat, resp, en_s, we_s, a_s, di_s);
        check("l3_rd_latency", 64'(lat), 64'd5);
        check("l3_rd_strobes", {50'd0, en_s, we_s, a_s}, {50'd0, 2'b01, 4'h0, 8'h02});

        // Asynchronous reset while a read sits in RWAIT
        @(negedge clk);
        adr = 32'h3000_0008; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {en_a[1], we_a[1], a_a[1], bus1.wb_ack_o, bus1.wb_err_o,
              bus1.wb_dat_o}, 64'd0);
        check("midrst_di", {32'd0, di_a[1]}, 64'd0);
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        last_rd[1] = 32'd0;
        ack_seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); @(negedge clk);
            ack_seen = ack_seen | ack_m | err_m;
        end
        check("midrst_no_ack", {63'd0, ack_seen}, 64'd0);

        run_xfer(1'b1, 32'h3000_040C, 32'h0BAD_F00D, 4'h3, lat, resp, en_s, we_s, a_s, di_s);
        check("postrst_latency", 64'(lat), 64'd1);
        check("postrst_strobes", {50'd0, en_s, we_s, a_s}, {50'd0, 2'b10, 4'h3, 8'h03});
        run_xfer(1'b0, 32'h3000_040C, 32'd0, 4'hF, lat, resp, en_s, we_s, a_s, di_s);
        check("postrst_rd_latency", 64'(lat), 64'd5);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
